// File: rtl/gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_pkg                                                                   |
// | Register offsets, default base addresses and decode helper for GPIO IP.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gpio_pkg;

    localparam logic [1:0] GPIO_IN_DATA       = 2'd0;
    localparam logic [1:0] GPIO_IN_IRQ_EN     = 2'd1;
    localparam logic [1:0] GPIO_IN_EDGE_SEL   = 2'd2;
    localparam logic [1:0] GPIO_IN_IRQ_STATUS = 2'd3;

    localparam logic [31:0] GPIO_OUT_BASE_ADDR_DEFAULT = 32'h2000_0000;
    localparam logic [31:0] GPIO_IN_BASE_ADDR_DEFAULT  = 32'h2000_0100;

    // Each block owns a 16-byte window, so only the upper 28 address bits decode.
    function automatic logic addr_hit(input logic [27:0] addr_hi, input logic [27:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_input_ip_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_input_ip_if                                                           |
// | Simple peripheral bus shared by the GPIO blocks.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface gpio_input_ip_if;

    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        write_enable;
    logic        read_enable;
    logic        chip_select;

    modport master (
        output addr,
        output write_data,
        output write_enable,
        output read_enable,
        output chip_select,
        input  read_data
    );

    modport slave (
        input  addr,
        input  write_data,
        input  write_enable,
        input  read_enable,
        input  chip_select,
        output read_data
    );

endinterface

`default_nettype wire

// File: rtl/gpio_in_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_in_sync                                                               |
// | 2-flop pin synchroniser; optional tick-based debouncer (GPIO_IN_DEBOUNCE_EN)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gpio_in_sync #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_async,
    output logic [WIDTH-1:0] pin_val
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync1_d;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sync2_d;

    always_comb begin
        sync1_d = pin_async;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;
    logic [WIDTH-1:0] samp_q;
    logic [WIDTH-1:0] samp_d;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] stable;

    // A bit only moves when two consecutive ticks saw the same synchronised level.
    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        stable = ~(sync2_q ^ samp_q);
        samp_d = samp_q;
        deb_d  = deb_q;
        if (tick) begin
            samp_d = sync2_q;
            deb_d  = (stable & sync2_q) | (~stable & deb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            samp_q <= '0;
            deb_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
            deb_q  <= deb_d;
        end
    end

    assign pin_val = deb_q;
`else
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYCLES < 2);
    assign pin_val    = sync2_q;
`endif

endmodule

`default_nettype wire

// File: rtl/gpio_input_ip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_input_ip                                                              |
// | Memory-mapped GPIO input: level read, edge status (W1C), level IRQ.        |
// | Optional debouncer via macro GPIO_IN_DEBOUNCE_EN.  Revision: 1.0           |
// +----------------------------------------------------------------------------+
module gpio_input_ip
    import gpio_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter logic [31:0] BASE_ADDR       = GPIO_IN_BASE_ADDR_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_input_ip_if.slave   bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    logic [WIDTH-1:0] pin_val;

    gpio_in_sync #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_async (gpio_in),
        .pin_val   (pin_val)
    );

    logic [WIDTH-1:0] prev_q,       prev_d;
    logic [WIDTH-1:0] irq_en_q,     irq_en_d;
    logic [WIDTH-1:0] edge_sel_q,   edge_sel_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [31:0]      read_data_q,  read_data_d;
    logic             irq_q,        irq_d;

    logic             hit;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       offset;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_mux;

    logic unused_bus;
    assign unused_bus = &{1'b0, bus.addr[1:0], bus.write_data};

    always_comb begin
        hit    = bus.chip_select && addr_hit(bus.addr[31:4], BASE_ADDR[31:4]);
        wr_en  = hit && bus.write_enable;
        rd_en  = hit && bus.read_enable;
        offset = bus.addr[3:2];
        wdata  = bus.write_data[WIDTH-1:0];
    end

    always_comb begin
        evt = (edge_sel_q & pin_val & ~prev_q) | (~edge_sel_q & ~pin_val & prev_q);
        w1c = (wr_en && offset == GPIO_IN_IRQ_STATUS) ? wdata : '0;

        prev_d       = pin_val;
        irq_en_d     = (wr_en && offset == GPIO_IN_IRQ_EN)   ? wdata : irq_en_q;
        edge_sel_d   = (wr_en && offset == GPIO_IN_EDGE_SEL) ? wdata : edge_sel_q;
        // New events are OR-ed in after the clear so a same-cycle set survives.
        irq_status_d = (irq_status_q & ~w1c) | evt;
        irq_d        = |(irq_status_q & irq_en_q);
    end

    // Read mux uses current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        unique case (offset)
            GPIO_IN_DATA:       rd_mux[WIDTH-1:0] = pin_val;
            GPIO_IN_IRQ_EN:     rd_mux[WIDTH-1:0] = irq_en_q;
            GPIO_IN_EDGE_SEL:   rd_mux[WIDTH-1:0] = edge_sel_q;
            GPIO_IN_IRQ_STATUS: rd_mux[WIDTH-1:0] = irq_status_q;
        endcase
        read_data_d = rd_en ? rd_mux : read_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            irq_en_q     <= '0;
            edge_sel_q   <= '0;
            irq_status_q <= '0;
            read_data_q  <= '0;
            irq_q        <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            irq_en_q     <= irq_en_d;
            edge_sel_q   <= edge_sel_d;
            irq_status_q <= irq_status_d;
            read_data_q  <= read_data_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.read_data = read_data_q;
    assign irq           = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_input_ip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gpio_input_ip                                                           |
// | Self-checking bench for gpio_input_ip.  Revision: 1.0                      |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gpio_input_ip;
    import gpio_pkg::*;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 1000;
`endif
    localparam logic [31:0] BASE = 32'h2000_0100;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] gpio_in = '0;
    logic        irq;

    gpio_input_ip_if bus ();

    gpio_input_ip #(
        .WIDTH           (32),
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .gpio_in (gpio_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: pins appear two edges after being driven, and the
    // previous level one edge after that; registers follow the register map.
    logic [31:0] pin_hist[$];
    logic [31:0] m_en, m_sel, m_st, m_rd;
    logic        m_irq;

    task automatic model_reset();
        pin_hist = '{32'h0, 32'h0, 32'h0};
        m_en = '0; m_sel = '0; m_st = '0; m_rd = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] pv, pp, evt, w1c;
        logic [31:0] regv[4];
        logic        hit, irq_next;
        logic [1:0]  off;
        pv  = pin_hist[1];
        pp  = pin_hist[2];
        evt = (m_sel & pv & ~pp) | (~m_sel & ~pv & pp);
        regv = '{pv, m_en, m_sel, m_st};
        hit = bus.chip_select && (bus.addr[31:4] == BASE[31:4]);
        off = bus.addr[3:2];
        w1c = '0;
        irq_next = ((m_st & m_en) != 0);
        if (hit && bus.read_enable) m_rd = regv[off];
        if (hit && bus.write_enable) begin
            case (off)
                2'd1:    m_en  = bus.write_data;
                2'd2:    m_sel = bus.write_data;
                2'd3:    w1c   = bus.write_data;
                default: ;
            endcase
        end
        m_st  = (m_st & ~w1c) | evt;
        m_irq = irq_next;
        pin_hist.push_front(gpio_in);
        void'(pin_hist.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic bus_set(input logic cs, input logic we, input logic re,
                           input logic [31:0] a, input logic [31:0] wd);
        bus.chip_select  = cs;
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.addr         = a;
        bus.write_data   = wd;
    endtask

    task automatic idle(input int n);
        bus_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [1:0] off);
        bus_set(1'b1, 1'b0, 1'b1, BASE + {28'h0, off, 2'b00}, 32'h0);
        step();
        bus_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] v);
        bus_set(1'b1, 1'b1, 1'b0, BASE + {28'h0, off, 2'b00}, v);
        step();
        bus_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic [31:0] gpio;
        logic        cs, we, re;
        logic [31:0] addr, wdata, exp_rd;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] g, input logic cs, input logic we,
                                input logic re, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] e, input logic ei);
        vec_t v;
        v.gpio = g; v.cs = cs; v.we = we; v.re = re;
        v.addr = a; v.wdata = wd; v.exp_rd = e; v.exp_irq = ei;
        return v;
    endfunction

`ifndef GPIO_IN_DEBOUNCE_EN
    task automatic run_default();
        vec_t        tbl[$];
        logic [31:0] g0, g1;
        g0 = 32'hFFFF_FFFF;
        g1 = 32'h1234_5678;
        tbl.push_back(mk(g0, 0, 0, 0, 0,                 0,            32'h0,         0));
        tbl.push_back(mk(g0, 0, 0, 0, 0,                 0,            32'h0,         0));
        tbl.push_back(mk(g0, 1, 0, 1, BASE + 32'h0,      0,            32'hFFFF_FFFF, 0));
        tbl.push_back(mk(g0, 1, 0, 1, BASE + 32'h4,      0,            32'h0,         0));
        tbl.push_back(mk(g0, 1, 0, 1, BASE + 32'h8,      0,            32'h0,         0));
        tbl.push_back(mk(g0, 1, 0, 1, BASE + 32'hC,      0,            32'h0,         0));
        tbl.push_back(mk(g1, 0, 0, 0, 0,                 0,            32'h0,         0));
        tbl.push_back(mk(g1, 0, 0, 0, 0,                 0,            32'h0,         0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'h0,      0,            32'h1234_5678, 0));
        tbl.push_back(mk(g1, 1, 0, 1, 32'h2000_0200,     0,            32'h1234_5678, 0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'hC,      0,            32'hEDCB_A987, 0));
        tbl.push_back(mk(g1, 1, 1, 1, BASE + 32'hC,      32'hFFFF_FFFF,32'hEDCB_A987, 0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'hC,      0,            32'h0,         0));
        tbl.push_back(mk(g1, 1, 1, 0, BASE + 32'h5,      32'h1,        32'h0,         0));
        tbl.push_back(mk(g1, 1, 1, 0, BASE + 32'h8,      32'h1,        32'h0,         0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'h6,      0,            32'h1,         0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'h8,      0,            32'h1,         0));
        tbl.push_back(mk(g1, 1, 1, 1, BASE + 32'h0,      32'hDEAD_BEEF,32'h1234_5678, 0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'h0,      0,            32'h1234_5678, 0));
        tbl.push_back(mk(g1, 0, 1, 1, BASE + 32'h4,      0,            32'h1234_5678, 0));
        tbl.push_back(mk(g1, 1, 0, 1, BASE + 32'h4,      0,            32'h1,         0));

        for (int i = 0; i < tbl.size(); i++) begin
            gpio_in = tbl[i].gpio;
            bus_set(tbl[i].cs, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
            step();
            chk($sformatf("vec%0d_rd", i), bus.read_data, tbl[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end

        // Rising edge on pin0 with IRQ_EN=1, EDGE_SEL=1
        gpio_in = 32'h1234_5679;
        idle(3);
        chk("rise_irq_pre", 32'(irq), 32'h0);
        rd(2'd3);
        chk("rise_status", bus.read_data, 32'h1);
        chk("rise_irq", 32'(irq), 32'h1);
        wr(2'd3, 32'h1);
        chk("w1c_irq_lag", 32'(irq), 32'h1);
        idle(1);
        chk("w1c_irq_clr", 32'(irq), 32'h0);
        rd(2'd3);
        chk("w1c_status", bus.read_data, 32'h0);
        gpio_in = 32'h1234_5678;
        idle(4);
        rd(2'd3);
        chk("rise_no_fall_evt", bus.read_data, 32'h0);
        chk("rise_no_fall_irq", 32'(irq), 32'h0);

        // Falling edge on pin5, masked, then enabled late
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h0);
        gpio_in = 32'h1234_5658;
        idle(4);
        rd(2'd3);
        chk("fall_status", bus.read_data, 32'h20);
        chk("fall_masked_irq", 32'(irq), 32'h0);
        wr(2'd1, 32'h20);
        chk("late_en_irq_b1", 32'(irq), 32'h0);
        idle(1);
        chk("late_en_irq_b2", 32'(irq), 32'h1);

        // Set and W1C of bit3 on the same edge
        wr(2'd3, 32'h20);
        wr(2'd2, 32'h8);
        gpio_in = 32'h1234_5650;
        idle(4);
        rd(2'd3);
        chk("coll_pre_status", bus.read_data, 32'h0);
        gpio_in = 32'h1234_5658;
        idle(2);
        wr(2'd3, 32'h8);
        rd(2'd3);
        chk("coll_set_wins", bus.read_data, 32'h8);
        wr(2'd1, 32'h8);
        idle(1);
        chk("coll_irq", 32'(irq), 32'h1);
        rd(2'd1);
        chk("coll_en_rd", bus.read_data, 32'h8);

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd", bus.read_data, 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(3);
        rd(2'd0);
        chk("post_rst_data", bus.read_data, 32'h1234_5658);
        rd(2'd1);
        chk("post_rst_en", bus.read_data, 32'h0);
        rd(2'd2);
        chk("post_rst_sel", bus.read_data, 32'h0);
        rd(2'd3);
        chk("post_rst_status", bus.read_data, 32'h0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  off;
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
            off = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? (32'h2000_0200 | {28'h0, off, 2'b00})
                                              : (BASE + {28'h0, off, 2'b00} + 32'($urandom_range(0, 3)));
            bus_set($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    1'($urandom_range(0, 1)), a, $urandom);
            step();
            chk($sformatf("rnd%0d_rd", i), bus.read_data, m_rd);
            chk($sformatf("rnd%0d_irq", i), 32'(irq), 32'(m_irq));
        end
        idle(1);
    endtask
`else
    task automatic run_debounce();
        int found;
        wr(2'd2, 32'h2);
        idle(8);
        gpio_in = 32'h2;
        idle(2);
        gpio_in = 32'h0;
        idle(12);
        rd(2'd0);
        chk("db_glitch_data", bus.read_data, 32'h0);
        rd(2'd3);
        chk("db_glitch_status", bus.read_data, 32'h0);
        gpio_in = 32'h2;
        found = -1;
        for (int i = 0; i < 14; i++) begin
            rd(2'd0);
            if (bus.read_data[1] && found < 0) found = i;
        end
        chk("db_latency_ok", 32'(found >= 0 && found <= 11), 32'h1);
        idle(4);
        rd(2'd3);
        chk("db_status", bus.read_data, 32'h2);
        rd(2'd0);
        chk("db_data", bus.read_data, 32'h2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        bus_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
`ifdef GPIO_IN_DEBOUNCE_EN
        gpio_in = 32'h0;
`else
        gpio_in = 32'hFFFF_FFFF;
`endif
        for (int i = 0; i < 3; i++) step();
        chk("rst_rd", bus.read_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
`ifdef GPIO_IN_DEBOUNCE_EN
        run_debounce();
`else
        run_default();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_input_ip.md
Name: gpio_input_ip

Overview:
Memory-mapped GPIO input peripheral; the read-side counterpart of gpio_output_ip on the same simple bus (addr/write_data/read_data/write_enable/read_enable/chip_select).
- Synchronises external pins and exposes their level.
- Detects per-pin edges and latches them into a write-1-to-clear status register.
- Drives one level interrupt to the CPU.

Parameters:
- WIDTH, 32, number of input pins (1..32); unused read_data bits read 0.
- BASE_ADDR, 32'h2000_0100, byte address of register 0; the block decodes BASE_ADDR..BASE_ADDR+0xF.
- DEBOUNCE_CYCLES, 1000, sample-tick period in clk cycles; used only with the optional feature; minimum 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  32  byte address.
- write_data  in  32  write data.
- read_data  out  32  registered read data.
- write_enable  in  1  write strobe, one cycle per write.
- read_enable  in  1  read strobe.
- chip_select  in  1  block select; must be high together with a strobe.
- gpio_in  in  WIDTH  asynchronous external pins.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- On reset, these all clear to 0: read_data, irq, sync stages, prev-sample, IRQ_EN, EDGE_SEL, IRQ_STATUS, prescaler.
- Access: hit = chip_select & (addr[31:4] == BASE_ADDR[31:4]); offset = addr[3:2]; addr[1:0] ignored.
- Register map:
  - 0x0 DATA (RO): current pin value.
  - 0x4 IRQ_EN (RW).
  - 0x8 EDGE_SEL (RW): 1 = rising, 0 = falling.
  - 0xC IRQ_STATUS (RW1C).
- Writes: on hit & write_enable, the register updates at that clock edge.
  - Writes to DATA are ignored.
  - On IRQ_STATUS, each written 1 clears the corresponding bit; written 0s have no effect.
- Reads: on hit & read_enable, read_data loads the selected register at that edge (1-cycle latency).
  - Otherwise read_data holds its last value.
  - read & write in the same cycle: the read returns the pre-write value.
- Input path: gpio_in -> sync1 -> sync2 (2-flop synchroniser); pin_val = sync2; prev <= pin_val every cycle.
  - DATA reflects a pin change 2 edges after it is captured by sync1.
- Edge detect: rise = pin_val & ~prev; fall = ~pin_val & prev; evt = EDGE_SEL ? rise : fall (bitwise).
  - evt bits set IRQ_STATUS at the edge where prev would take the new value (3rd edge after capture).
- Simultaneous set and W1C on the same bit: set wins; the bit stays 1.
- Status bits latch regardless of IRQ_EN; enabling later raises irq if the status bit is already set.
- irq <= |(IRQ_STATUS & IRQ_EN), registered, so irq follows status by one cycle.
- Changing EDGE_SEL does not itself generate an event.
- Reset mid-operation returns everything to reset values immediately; pending status is lost.

Optional Feature:
Macro: GPIO_IN_DEBOUNCE_EN
- Defined:
  - A prescaler counts 0..DEBOUNCE_CYCLES-1 and emits a one-cycle tick at wrap.
  - On each tick, samp <= sync2. pin_val bit updates to sync2 only if sync2 == samp for that bit, i.e. the value is stable across two consecutive ticks.
  - Edge detect and DATA use this debounced pin_val.
  - Worst-case latency from a pin change is 2*DEBOUNCE_CYCLES + 3 cycles.
- Undefined: no prescaler or samp registers; pin_val = sync2 as above.

Decomposition:
- Package gpio_pkg holds:
  - offset constants GPIO_IN_DATA = 2'd0, GPIO_IN_IRQ_EN = 2'd1, GPIO_IN_EDGE_SEL = 2'd2, GPIO_IN_IRQ_STATUS = 2'd3.
  - default BASE_ADDR constants for both GPIO blocks.
- One natural sub-module: gpio_in_sync, the WIDTH-bit 2-flop synchroniser plus the optional debouncer under GPIO_IN_DEBOUNCE_EN.
- The bus decode and register file stay in the top module.

Test Plan:
- Reset/defaults: hold rst_n=0 with gpio_in=32'hFFFF_FFFF, release, read 0x0/0x4/0x8/0xC -> DATA=FFFF_FFFF (after 2 cycles), others 0, irq=0, no status set during reset release.
- Level read: gpio_in=32'h1234_5678 -> read DATA 3 cycles later = 1234_5678; unmapped addr 2000_0200 with chip_select=1 -> read_data unchanged.
- Rising IRQ: IRQ_EN=1, EDGE_SEL=1, pin0 0->1 -> IRQ_STATUS=1 at 3rd edge, irq=1 one cycle later; write 1 to 0xC -> status 0, irq 0 next cycle; pin0 1->0 -> no event.
- Falling IRQ plus masking: EDGE_SEL=0, IRQ_EN=0, pin5 1->0 -> IRQ_STATUS=32'h20, irq stays 0; write IRQ_EN=32'h20 -> irq=1 two edges later.
- Collision: a W1C of bit 3 in the same cycle that a bit-3 edge is latched -> IRQ_STATUS[3] remains 1; async rst_n pulse mid-sequence -> all registers 0 without a clock edge.
- Debounce (macro defined, DEBOUNCE_CYCLES=4): 2-cycle glitch on pin1 -> DATA unchanged, no status; level held for 12 cycles -> DATA[1]=1 within 11 cycles, one status bit set.
